// File: rtl/pdm_decimator.sv
// 3rd-order CIC decimator: turns a 1-bit PDM stream into signed OUT_W-bit PCM.
// Modular integrators, decimation counter, registered comb pipeline, saturating output.
module pdm_decimator #(
    parameter int unsigned DECIM_LOG2 = 5,
    parameter int unsigned OUT_W      = 10,
    parameter bit          INVERT     = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             din,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    output logic             sample_clip
);

    localparam int unsigned ACC_W = 3 * DECIM_LOG2 + 2;
    localparam int unsigned Y_W   = ACC_W + OUT_W;
    localparam int unsigned SHR   = (3 * DECIM_LOG2 >= OUT_W - 1) ? 3 * DECIM_LOG2 - (OUT_W - 1) : 0;
    localparam int unsigned SHL   = (3 * DECIM_LOG2 >= OUT_W - 1) ? 0 : (OUT_W - 1) - 3 * DECIM_LOG2;

    localparam logic signed [Y_W-1:0] Y_MAX = Y_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [Y_W-1:0] Y_MIN = ~Y_MAX;

    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]      i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [ACC_W-1:0]      c1_q, c1_d, c2_q, c2_d;
    logic [ACC_W-1:0]      d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic                  stb_q, stb_d, v1_q, v1_d, v2_q, v2_d;
    logic [1:0]            warm_q, warm_d;
    logic [OUT_W-1:0]      sample_q, sample_d;
    logic                  valid_q, valid_d, clip_q, clip_d;

    logic [ACC_W-1:0]      x;
    logic [ACC_W-1:0]      c3;
    logic signed [Y_W-1:0] c3_ext;
    logic signed [Y_W-1:0] y;

    always_comb begin
        cnt_d    = cnt_q;
        i1_d     = i1_q;
        i2_d     = i2_q;
        i3_d     = i3_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        d3_d     = d3_q;
        warm_d   = warm_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        clip_d   = 1'b0;

        x = (din ^ INVERT) ? ACC_W'(1) : {ACC_W{1'b1}};

        // Integrators chain within the cycle so I3 already includes the current bit
        if (bit_en) begin
            i1_d  = i1_q + x;
            i2_d  = i2_q + i1_d;
            i3_d  = i3_q + i2_d;
            cnt_d = cnt_q + DECIM_LOG2'(1);
        end
        stb_d = bit_en && (cnt_q == {DECIM_LOG2{1'b1}});

        v1_d = stb_q;
        if (stb_q) begin
            c1_d = i3_q - d1_q;
            d1_d = i3_q;
        end

        v2_d = v1_q;
        if (v1_q) begin
            c2_d = c1_q - d2_q;
            d2_d = c1_q;
        end

        // Last comb stage feeds the output register directly
        c3     = c2_q - d3_q;
        c3_ext = {{OUT_W{c3[ACC_W-1]}}, c3};
        y      = (c3_ext >>> SHR) <<< SHL;

        if (v2_q) begin
            d3_d = c2_q;
            if (warm_q == 2'd3) begin
                valid_d = 1'b1;
                if (y > Y_MAX) begin
                    sample_d = {1'b0, {(OUT_W - 1){1'b1}}};
                    clip_d   = 1'b1;
                end else if (y < Y_MIN) begin
                    sample_d = {1'b1, {(OUT_W - 1){1'b0}}};
                    clip_d   = 1'b1;
                end else begin
                    sample_d = y[OUT_W-1:0];
                end
            end else begin
                warm_d = warm_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            stb_q    <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            warm_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            i3_q     <= i3_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
            stb_q    <= stb_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            warm_q   <= warm_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            clip_q   <= clip_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign sample_clip  = clip_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: two instances (INVERT=0/1) against a convolution model
// of the CIC impulse response with warm-up, latency and saturation rules.
module tb_pdm_decimator;

    localparam int DL    = 5;
    localparam int OUT_W = 10;
    localparam int R     = 1 << DL;
    localparam int HLEN  = 3 * R - 2;
    localparam int SH    = 3 * DL - (OUT_W - 1);
    localparam int YMAX  = (1 << (OUT_W - 1)) - 1;
    localparam int YMIN  = -(1 << (OUT_W - 1));

    logic clk = 1'b0;
    logic reset, bit_en, din;
    logic [OUT_W-1:0] s0, s1;
    logic v0, v1, c0, c1;

    always #5 clk = ~clk;

    pdm_decimator #(.DECIM_LOG2(DL), .OUT_W(OUT_W), .INVERT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .bit_en(bit_en), .din(din),
        .sample(s0), .sample_valid(v0), .sample_clip(c0)
    );

    pdm_decimator #(.DECIM_LOG2(DL), .OUT_W(OUT_W), .INVERT(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .bit_en(bit_en), .din(din),
        .sample(s1), .sample_valid(v1), .sample_clip(c1)
    );

    typedef struct {
        int due;
        int c3;
    } ev_t;

    int  h [HLEN];
    int  hist[$];
    ev_t pend[$];
    int  n_bits, n_stb, cyc, pidx;
    int  exp_s0, exp_s1;
    bit  exp_v, exp_c0, exp_c1;
    int  checks   = 0;
    int  failures = 0;

    // CIC impulse response: three length-R boxcars convolved
    task automatic build_h();
        for (int k = 0; k < HLEN; k++) h[k] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a + b + c] = h[a + b + c] + 1;
    endtask

    function automatic int conv();
        int acc = 0;
        for (int k = 0; k < HLEN; k++) acc += h[k] * hist[k];
        return acc;
    endfunction

    task automatic scale(input int c3, output int y, output bit clip);
        y    = c3 >>> SH;
        clip = 1'b0;
        if (y > YMAX) begin y = YMAX; clip = 1'b1; end
        else if (y < YMIN) begin y = YMIN; clip = 1'b1; end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < HLEN; k++) hist.push_back(0);
        pend.delete();
        n_bits = 0; n_stb = 0; pidx = 0;
        exp_s0 = 0; exp_s1 = 0; exp_v = 1'b0; exp_c0 = 1'b0; exp_c1 = 1'b0;
    endtask

    task automatic check();
        checks++;
        assert (v0 === exp_v) else begin
            failures++;
            $error("FAIL valid0 cyc=%0d observed=%0b expected=%0b", cyc, v0, exp_v);
        end
        checks++;
        assert (v1 === exp_v) else begin
            failures++;
            $error("FAIL valid1 cyc=%0d observed=%0b expected=%0b", cyc, v1, exp_v);
        end
        checks++;
        assert (s0 === OUT_W'(exp_s0)) else begin
            failures++;
            $error("FAIL sample0 cyc=%0d observed=%0d expected=%0d", cyc, $signed(s0), exp_s0);
        end
        checks++;
        assert (s1 === OUT_W'(exp_s1)) else begin
            failures++;
            $error("FAIL sample1 cyc=%0d observed=%0d expected=%0d", cyc, $signed(s1), exp_s1);
        end
        if (exp_v) begin
            checks++;
            assert (c0 === exp_c0) else begin
                failures++;
                $error("FAIL clip0 cyc=%0d observed=%0b expected=%0b", cyc, c0, exp_c0);
            end
            checks++;
            assert (c1 === exp_c1) else begin
                failures++;
                $error("FAIL clip1 cyc=%0d observed=%0b expected=%0b", cyc, c1, exp_c1);
            end
        end
    endtask

    // One clock: drive inputs, advance model across the edge, compare
    task automatic tick(input logic rst, input logic be, input logic d);
        ev_t ev;
        int  y;
        bit  cl;
        reset = rst; bit_en = be; din = d;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            exp_v = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ev = pend.pop_front();
                scale(ev.c3, y, cl);  exp_s0 = y; exp_c0 = cl;
                scale(-ev.c3, y, cl); exp_s1 = y; exp_c1 = cl;
                exp_v = 1'b1;
            end
            if (be) begin
                hist.push_front(d ? 1 : -1);
                void'(hist.pop_back());
                n_bits++;
                pidx++;
                if (n_bits % R == 0) begin
                    n_stb++;
                    if (n_stb >= 4) begin
                        ev.due = cyc + 3;
                        ev.c3  = conv();
                        pend.push_back(ev);
                    end
                end
            end
        end
        check();
    endtask

    function automatic logic pat(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (pidx % 2 == 0);
            3:       return (pidx % 4 != 3);
            default: return 1'($urandom % 2);
        endcase
    endfunction

    task automatic run(input int n, input int mode, input int period);
        for (int i = 0; i < n; i++) begin
            logic be;
            be = (i % period == period - 1);
            tick(1'b0, be, pat(mode));
        end
    endtask

    initial begin
        reset = 1'b1; bit_en = 1'b0; din = 1'b0;
        cyc = 0;
        build_h();
        model_reset();

        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        run(200, 0, 1);             // full-scale positive

        tick(1'b1, 1'b0, 1'b0);
        run(200, 1, 1);             // full-scale negative

        tick(1'b1, 1'b0, 1'b0);
        run(200, 2, 1);             // alternating, zero mean

        tick(1'b1, 1'b0, 1'b0);
        run(200, 3, 1);             // 1,1,1,0 -> half scale

        tick(1'b1, 1'b0, 1'b0);
        run(600, 3, 3);             // sparse bit_en

        // Reset while a comb token is in flight
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, 1'b1, pat(3));
            if (n_bits >= 160 && n_bits % R == 0) break;
        end
        tick(1'b0, 1'b1, pat(3));
        tick(1'b1, 1'b1, 1'b1);
        run(200, 3, 1);

        // Random duty cycle and data with occasional resets
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            logic rst;
            rst = ($urandom % 700 == 0);
            tick(rst, 1'($urandom % 4 != 0), 1'($urandom % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
